// File: rtl/regfile_pkg.sv
// Shared register-file types and widths, used by writeback, the register file and decode.
package regfile_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned NUM_REGS = 2 ** REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    logic [NUM_REGS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order circular FIFO with two push ports (a before b) and one pop port.
// Exposes per-slot occupancy and contents so the parent can scan queued entries.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 19,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_a,
  input  logic [WIDTH-1:0]       data_a,
  input  logic                   push_b,
  input  logic [WIDTH-1:0]       data_b,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [CntW-1:0]        count,
  output logic [DEPTH-1:0]       occupied,
  output logic [DEPTH*WIDTH-1:0] entries
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [CntW-1:0]  count_q;
  logic [PtrW-1:0]  wr_b;

  // Port b lands behind port a when both push on the same edge.
  assign wr_b = wr_q + PtrW'(push_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_a) mem_q[wr_q] <= data_a;
      if (push_b) mem_q[wr_b] <= data_b;
      wr_q    <= wr_q + PtrW'(push_a) + PtrW'(push_b);
      rd_q    <= rd_q + PtrW'(pop);
      count_q <= count_q + CntW'(push_a) + CntW'(push_b) - CntW'(pop);
    end
  end

  always_comb begin
    logic [PtrW-1:0] off;
    occupied = '0;
    entries  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = PtrW'(i) - rd_q;
      occupied[i] = CntW'(off) < count_q;
      entries[i*WIDTH +: WIDTH] = mem_q[i];
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write front end: arbitrates ALU/load results into an in-order queue,
// drives one registered write per cycle and exports a per-register pending-write mask.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned REG_AW = regfile_pkg::REG_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_AW-1:0]    alu_dest,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_AW-1:0]    ld_dest,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 wb_stall,
  output logic [REG_AW-1:0]    DEST,
  output logic [DATA_W-1:0]    w_in,
  output logic                 w_en,
  output logic [2**REG_AW-1:0] busy
);

  localparam int unsigned EntW = REG_AW + DATA_W;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic                   ld_push, alu_push, pop;
  logic                   push_a, push_b;
  logic [EntW-1:0]        data_a, data_b, head;
  logic [CntW-1:0]        count;
  logic [DEPTH-1:0]       occupied;
  logic [DEPTH*EntW-1:0]  entries;

  logic                   w_en_q;
  logic [REG_AW-1:0]      dest_q;
  logic [DATA_W-1:0]      data_q;

  // Readies look only at the pre-edge count; a same-edge pop never frees a slot.
  always_comb begin
    ld_ready  = reset && (count < CntW'(DEPTH));
    ld_push   = ld_valid && ld_ready;
    alu_ready = reset && ((count + CntW'(ld_push)) < CntW'(DEPTH));
    alu_push  = alu_valid && alu_ready;
    push_a    = ld_push || alu_push;
    data_a    = ld_push ? {ld_dest, ld_data} : {alu_dest, alu_data};
    push_b    = ld_push && alu_push;
    data_b    = {alu_dest, alu_data};
    pop       = (count != '0) && !wb_stall;
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push_a   (push_a),
    .data_a   (data_a),
    .push_b   (push_b),
    .data_b   (data_b),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .occupied (occupied),
    .entries  (entries)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_en_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else begin
      w_en_q <= pop;
      if (pop) {dest_q, data_q} <= head;
    end
  end

  assign DEST = dest_q;
  assign w_in = data_q;
  assign w_en = w_en_q;

  // Busy is built only from registered state, so decode sees no input-to-output path.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i]) busy[entries[i*EntW + DATA_W +: REG_AW]] = 1'b1;
    end
    if (w_en_q) busy[dest_q] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: directed scenarios plus random traffic.
module tb_regfile_writeback;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid = 1'b0, ld_valid = 1'b0, wb_stall = 1'b0;
  logic        alu_ready, ld_ready;
  logic [2:0]  alu_dest = '0, ld_dest = '0;
  logic [15:0] alu_data = '0, ld_data = '0;
  logic [2:0]  DEST;
  logic [15:0] w_in;
  logic        w_en;
  logic [7:0]  busy;

  always #5 clk = ~clk;

  regfile_writeback #(
    .DEPTH  (DEPTH),
    .DATA_W (16),
    .REG_AW (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_dest  (alu_dest),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_dest   (ld_dest),
    .ld_data   (ld_data),
    .wb_stall  (wb_stall),
    .DEST      (DEST),
    .w_in      (w_in),
    .w_en      (w_en),
    .busy      (busy)
  );

  int          n_vec = 0;
  int          n_err = 0;
  wb_entry_t   sb[$];        // accepted writes not yet seen on the write port
  int          cnt = 0;      // model queue occupancy
  bit          exp_wen = 1'b0;
  logic [15:0] rf_dut [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, predict readies, then update the model at posedge.
  task automatic cycle(input bit lv, input logic [2:0] ldd, input logic [15:0] ldx,
                       input bit av, input logic [2:0] ald, input logic [15:0] alx,
                       input bit st);
    bit exp_lr, exp_ar, p;
    @(negedge clk);
    ld_valid = lv;  ld_dest = ldd;  ld_data = ldx;
    alu_valid = av; alu_dest = ald; alu_data = alx;
    wb_stall = st;
    #2;
    exp_lr = reset && (cnt < DEPTH);
    exp_ar = reset && ((cnt + int'(lv && exp_lr)) < DEPTH);
    check("ld_ready", ld_ready, exp_lr);
    check("alu_ready", alu_ready, exp_ar);
    @(posedge clk);
    p       = reset && (cnt > 0) && !st;
    exp_wen = p;
    cnt     = cnt - int'(p);
    if (lv && exp_lr) begin
      sb.push_back(wb_entry_t'{dest: ldd, data: ldx});
      cnt++;
    end
    if (av && exp_ar) begin
      sb.push_back(wb_entry_t'{dest: ald, data: alx});
      cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0);
  endtask

  // Reset asserted mid-cycle with offers pending; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    ld_valid = 1'b1; alu_valid = 1'b1; wb_stall = 1'b0;
    #2;
    reset = 1'b0;
    sb.delete();
    cnt     = 0;
    exp_wen = 1'b0;
    #1;
    check("rst_w_en", w_en, 1'b0);
    check("rst_busy", busy, 8'h00);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_alu_ready", alu_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0; alu_valid = 1'b0;
    reset = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a write is presented.
  initial begin
    wb_entry_t  e;
    logic [7:0] busy_exp;
    forever begin
      @(posedge clk);
      #1;
      check("w_en", w_en, exp_wen);
      busy_exp = '0;
      if (w_en === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL write: DEST=%0d w_in=%0h presented, expected no write at %0t",
                   DEST, w_in, $time);
        end else begin
          e = sb.pop_front();
          check("DEST", DEST, e.dest);
          check("w_in", w_in, e.data);
          busy_exp[e.dest] = 1'b1;
          rf_dut[DEST] = w_in;
        end
      end
      foreach (sb[i]) busy_exp[sb[i].dest] = 1'b1;
      check("busy", busy, busy_exp);
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 8; i++) rf_dut[i] = '0;
    #1 reset = 1'b0;
    #2;
    check("init_w_en", w_en, 1'b0);
    check("init_busy", busy, 8'h00);
    check("init_DEST", DEST, 3'd0);
    check("init_w_in", w_in, 16'h0);
    @(negedge clk);
    reset = 1'b1;

    // Single ALU result into an empty queue.
    cycle(0, 3'd0, 16'h0, 1, 3'd1, 16'hAAAA, 0);
    idle(3);

    // Simultaneous offers: load first, ALU second.
    cycle(1, 3'd3, 16'hCCCC, 1, 3'd4, 16'hDDDD, 0);
    idle(4);

    // Stall fills the queue, readies drop, then four back-to-back writes.
    cycle(1, 3'd0, 16'h1000, 1, 3'd1, 16'h1001, 1);
    cycle(1, 3'd2, 16'h1002, 1, 3'd5, 16'h1005, 1);
    cycle(1, 3'd7, 16'h1007, 1, 3'd7, 16'h1008, 1);
    idle(6);

    // One free slot: load wins, ALU waits until a pop has freed space.
    cycle(1, 3'd2, 16'h2002, 1, 3'd3, 16'h2003, 1);
    cycle(1, 3'd4, 16'h2004, 0, 3'd0, 16'h0, 1);
    cycle(1, 3'd5, 16'h2005, 1, 3'd6, 16'h2006, 1);
    cycle(0, 3'd0, 16'h0, 1, 3'd6, 16'h2006, 0);
    cycle(0, 3'd0, 16'h0, 1, 3'd6, 16'h2006, 0);
    idle(6);

    // Two writes to r6: the later value must be the one left in the register file.
    cycle(0, 3'd0, 16'h0, 1, 3'd6, 16'h1111, 0);
    cycle(0, 3'd0, 16'h0, 1, 3'd6, 16'hFFFF, 0);
    idle(4);
    check("r6_final", rf_dut[6], 16'hFFFF);

    // Reset with three entries queued: nothing stale may issue afterwards.
    cycle(1, 3'd1, 16'h3001, 1, 3'd2, 16'h3002, 1);
    cycle(1, 3'd3, 16'h3003, 0, 3'd0, 16'h0, 1);
    do_reset();
    idle(5);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
            bit'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
            $urandom_range(0, 3) == 0);
    end

    // Drain, bounded.
    guard = 0;
    while ((cnt > 0 || exp_wen) && guard < 20) begin
      idle(1);
      guard++;
    end
    idle(2);
    check("drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
